led_sequencer: RTL and testbench

LED_SEQUENCER -- requirements
Module: led_sequencer

---
 rtl/led_sequencer.sv | 194 +++++++++++++++++++
 tb/tb_led_sequencer.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/led_sequencer.sv
// ----------------------------------------------------------------------------
// led_sequencer
//
// Drives an external 16-bit LED output register through a one-cycle write
// strobe. A small register bank (CTRL, PATTERN, PERIOD, CUR) is accessed over
// a simple select/strobe bus. Once started, a prescaler divides clk by
// PERIOD+1. On each tick the displayed byte is updated according to the
// selected mode (STATIC, BLINK, ROTATE, COUNT), and the new value is pushed
// to the LED register.
//
// Ports
//   clk       : single clock, rising edge
//   rst_n     : asynchronous active-low reset
//   en        : bus select for this block
//   wr_en     : 1 = write, 0 = read (qualified by en)
//   addr      : 0 CTRL, 1 PATTERN, 2 PERIOD, 3 CUR (read-only)
//   data_in   : bus write data
//   data_out  : registered read data, holds between reads
//   led_wr    : one-cycle write strobe to the LED output register
//   led_data  : LED register write data, bits 15:8 always zero
// ----------------------------------------------------------------------------
module led_sequencer #(
    parameter logic [15:0] DEF_PERIOD = 16'd49999
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic        wr_en,
    input  logic [1:0]  addr,
    input  logic [15:0] data_in,
    output logic [15:0] data_out,
    output logic        led_wr,
    output logic [15:0] led_data
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2
    } state_t;

    localparam logic [1:0] MODE_STATIC = 2'b00;
    localparam logic [1:0] MODE_BLINK  = 2'b01;
    localparam logic [1:0] MODE_ROTATE = 2'b10;
    localparam logic [1:0] MODE_COUNT  = 2'b11;

    localparam logic [1:0] ADDR_CTRL    = 2'd0;
    localparam logic [1:0] ADDR_PATTERN = 2'd1;
    localparam logic [1:0] ADDR_PERIOD  = 2'd2;
    localparam logic [1:0] ADDR_CUR     = 2'd3;

    state_t      state;
    logic        run;
    logic [1:0]  mode;
    logic [7:0]  pattern;
    logic [15:0] period;
    logic [15:0] cnt;
    logic        phase;
    logic [7:0]  cur;

    logic        bus_wr;
    logic        bus_rd;
    logic        ctrl_wr;
    logic        new_run;
    logic [1:0]  new_mode;
    logic        reload_wr;
    logic        tick;
    logic [7:0]  tick_cur;

    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path
        // leaves one unassigned and no latch is inferred.
        bus_wr    = en & wr_en;
        bus_rd    = en & ~wr_en;
        ctrl_wr   = bus_wr && (addr == ADDR_CTRL);
        new_run   = data_in[2];
        new_mode  = data_in[1:0];

        // Writes that restart the sequence from PATTERN. A CTRL write that
        // keeps run set and leaves mode alone is deliberately not one of them.
        reload_wr = bus_wr && ((addr == ADDR_PATTERN) ||
                               (addr == ADDR_PERIOD)  ||
                               ((addr == ADDR_CTRL) && new_run && (new_mode != mode)));

        tick      = run && (state == RUN) && (cnt == period);

        tick_cur  = cur;
        case (mode)
            MODE_BLINK:  tick_cur = phase ? pattern : 8'h00;  // phase is about to toggle
            MODE_ROTATE: tick_cur = {cur[6:0], cur[7]};
            MODE_COUNT:  tick_cur = cur + 8'd1;
            default:     tick_cur = cur;
        endcase
    end

    // NOTE: all state below is updated with non-blocking assignments so every
    // register sees the pre-edge values of the others, independent of order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            run      <= 1'b0;
            mode     <= MODE_STATIC;
            pattern  <= 8'h00;
            period   <= DEF_PERIOD;
            cnt      <= 16'd0;
            phase    <= 1'b0;
            cur      <= 8'h00;
            led_wr   <= 1'b0;
            led_data <= 16'h0000;
            data_out <= 16'h0000;
        end else begin
            led_wr <= 1'b0;

            // Register bank. Bits above each register's width are dropped.
            if (bus_wr) begin
                case (addr)
                    ADDR_CTRL: begin
                        run  <= new_run;
                        mode <= new_mode;
                    end
                    ADDR_PATTERN: pattern <= data_in[7:0];
                    ADDR_PERIOD:  period  <= data_in;
                    default: ;  // CUR is read-only
                endcase
            end

            if (bus_rd) begin
                case (addr)
                    ADDR_CTRL:    data_out <= {13'b0, run, mode};
                    ADDR_PATTERN: data_out <= {8'h00, pattern};
                    ADDR_PERIOD:  data_out <= period;
                    ADDR_CUR:     data_out <= {8'h00, cur};
                    default:      data_out <= 16'h0000;
                endcase
            end

            // Sequencer. Clearing run wins from any active state and blanks
            // the LEDs once; a tick in the same cycle is simply dropped.
            if (ctrl_wr && !new_run) begin
                if (state != IDLE) begin
                    state    <= IDLE;
                    cur      <= 8'h00;
                    cnt      <= 16'd0;
                    phase    <= 1'b0;
                    led_wr   <= 1'b1;
                    led_data <= 16'h0000;
                end
            end else begin
                case (state)
                    IDLE: begin
                        if (ctrl_wr && new_run) begin
                            state <= LOAD;
                        end
                    end

                    LOAD: begin
                        // A reconfiguring write landing here postpones the
                        // load by a cycle so it picks up the new values.
                        if (!reload_wr) begin
                            cur      <= pattern;
                            cnt      <= 16'd0;
                            phase    <= 1'b0;
                            led_wr   <= 1'b1;
                            led_data <= {8'h00, pattern};
                            state    <= RUN;
                        end
                    end

                    RUN: begin
                        if (reload_wr) begin
                            // Bus write beats a coincident tick.
                            state <= LOAD;
                        end else if (tick) begin
                            cnt <= 16'd0;
                            if (mode != MODE_STATIC) begin
                                if (mode == MODE_BLINK) begin
                                    phase <= ~phase;
                                end
                                cur      <= tick_cur;
                                led_wr   <= 1'b1;
                                led_data <= {8'h00, tick_cur};
                            end
                        end else begin
                            cnt <= cnt + 16'd1;
                        end
                    end

                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_led_sequencer.sv
// ----------------------------------------------------------------------------
// tb_led_sequencer
//
// Directed and randomized stimulus for led_sequencer. Expected LED writes are
// computed from the sequencing rules: after a start write sampled at edge w,
// the k-th write appears at cycle w+1+k*(PERIOD+1) with a value that is a
// closed-form function of PATTERN, mode and k.
// ----------------------------------------------------------------------------
module tb_led_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic        wr_en = 1'b0;
    logic [1:0]  addr = 2'd0;
    logic [15:0] data_in = 16'h0000;
    logic [15:0] data_out;
    logic        led_wr;
    logic [15:0] led_data;

    led_sequencer dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .wr_en    (wr_en),
        .addr     (addr),
        .data_in  (data_in),
        .data_out (data_out),
        .led_wr   (led_wr),
        .led_data (led_data)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Log of every LED write: cycle in which led_wr was high, and its data.
    int          log_cyc[$];
    logic [15:0] log_dat[$];
    always @(negedge clk) begin
        if (led_wr) begin
            log_cyc.push_back(cyc);
            log_dat.push_back(led_data);
        end
    end

    int checks = 0;
    int errors = 0;

    initial begin
        #500000;
        $display("FAIL timeout reached before end of test");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) step();
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [15:0] d, output int wc);
        en = 1'b1; wr_en = 1'b1; addr = a; data_in = d;
        step();
        wc = cyc;
        en = 1'b0; wr_en = 1'b0; data_in = 16'h0000;
    endtask

    task automatic bus_read(input logic [1:0] a, output logic [15:0] d);
        en = 1'b1; wr_en = 1'b0; addr = a;
        step();
        d = data_out;
        en = 1'b0;
    endtask

    function automatic logic [7:0] rotl(input logic [7:0] p, input int r);
        int v;
        int rr;
        v  = p;
        rr = r % 8;
        return 8'(((v << rr) | (v >> (8 - rr))) & 255);
    endfunction

    // Value of the k-th LED write after a start (k = 0 is the load itself).
    function automatic logic [15:0] exp_val(input int mode, input logic [7:0] p, input int k);
        case (mode)
            1:       return (k % 2 == 0) ? {8'h00, p} : 16'h0000;
            2:       return {8'h00, rotl(p, k)};
            3:       return 16'((p + k) % 256);
            default: return {8'h00, p};
        endcase
    endfunction

    // Compare every logged write up to cycle hi against the expected train.
    task automatic check_window(input string tag, input int w, input int hi,
                                input int mode, input logic [7:0] p, input int per);
        int          ec[$];
        logic [15:0] ed[$];
        int          oc[$];
        logic [15:0] od[$];
        int          n;
        for (int k = 0; w + 1 + k * (per + 1) <= hi; k++) begin
            ec.push_back(w + 1 + k * (per + 1));
            ed.push_back(exp_val(mode, p, k));
            if (mode == 0) break;
        end
        foreach (log_cyc[i]) begin
            if (log_cyc[i] <= hi) begin
                oc.push_back(log_cyc[i]);
                od.push_back(log_dat[i]);
            end
        end
        check({tag, "_count"}, oc.size(), ec.size());
        n = (oc.size() < ec.size()) ? oc.size() : ec.size();
        for (int i = 0; i < n; i++) begin
            check($sformatf("%s_cyc%0d", tag, i), oc[i] - w, ec[i] - w);
            check($sformatf("%s_dat%0d", tag, i), od[i], ed[i]);
        end
    endtask

    task automatic start_seq(input string tag, input int mode, input logic [7:0] p,
                             input int per, output int w);
        logic [15:0] junk;
        logic [15:0] rd;
        int          dummy;
        junk = 16'($urandom);
        bus_write(2'd1, {junk[15:8], p}, dummy);
        bus_write(2'd2, 16'(per), dummy);
        bus_read(2'd1, rd);
        check({tag, "_pattern_rb"}, rd, {8'h00, p});
        bus_read(2'd2, rd);
        check({tag, "_period_rb"}, rd, 16'(per));
        log_cyc.delete();
        log_dat.delete();
        bus_write(2'd0, 16'(4 + mode), w);
    endtask

    task automatic stop_seq(input string tag);
        int          w2;
        int          n;
        logic [15:0] v;
        logic [15:0] rd;
        n = 0;
        v = 16'hFFFF;
        log_cyc.delete();
        log_dat.delete();
        bus_write(2'd0, 16'h0000, w2);
        wait_until(w2 + 5);
        foreach (log_cyc[i]) begin
            if (log_cyc[i] >= w2) begin
                n++;
                if (n == 1) begin
                    v = log_dat[i];
                    check({tag, "_stop_cyc"}, log_cyc[i] - w2, 0);
                end
            end
        end
        check({tag, "_stop_count"}, n, 1);
        check({tag, "_stop_dat"}, v, 16'h0000);
        bus_read(2'd3, rd);
        check({tag, "_stop_cur"}, rd, 16'h0000);
        bus_read(2'd0, rd);
        check({tag, "_stop_ctrl"}, rd, 16'h0000);
    endtask

    initial begin
        int          w;
        int          wc;
        int          mode;
        int          per;
        int          len;
        logic [7:0]  p;
        logic [15:0] rd;

        // ---------------- reset state ----------------
        #1;
        check("rst_led_wr", led_wr, 1'b0);
        check("rst_led_data", led_data, 16'h0000);
        check("rst_data_out", data_out, 16'h0000);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        bus_read(2'd2, rd);
        check("rst_period", rd, 16'd49999);
        bus_read(2'd0, rd);
        check("rst_ctrl", rd, 16'h0000);
        bus_read(2'd1, rd);
        check("rst_pattern", rd, 16'h0000);
        bus_write(2'd3, 16'hFFFF, wc);
        bus_read(2'd3, rd);
        check("cur_readonly", rd, 16'h0000);
        check("rst_no_led_wr", log_cyc.size(), 0);

        // ---------------- STATIC, PERIOD=0 ----------------
        start_seq("static", 0, 8'hA5, 0, w);
        wait_until(w + 12);
        check_window("static", w, w + 11, 0, 8'hA5, 0);
        bus_read(2'd3, rd);
        check("static_cur", rd, 16'h00A5);
        bus_read(2'd0, rd);
        check("static_ctrl", rd, 16'h0004);
        stop_seq("static");

        // ---------------- ROTATE, PERIOD=2, no-op CTRL write mid-run ----------------
        start_seq("rotate", 2, 8'h81, 2, w);
        wait_until(w + 4);
        bus_write(2'd0, 16'hFFF8 | 16'h0006, wc);  // run|ROTATE plus ignored upper bits
        wait_until(w + 12);
        check_window("rotate", w, w + 11, 2, 8'h81, 2);
        stop_seq("rotate");

        // ---------------- COUNT, PERIOD=0, wrap ----------------
        start_seq("count", 3, 8'hFE, 0, w);
        wait_until(w + 7);
        check_window("count", w, w + 6, 3, 8'hFE, 0);
        stop_seq("count");

        // ---------------- BLINK, PERIOD=1, PATTERN write on a tick ----------------
        start_seq("blink", 1, 8'h3C, 1, w);
        wait_until(w + 6);
        check_window("blink", w, w + 5, 1, 8'h3C, 1);
        // Tick due at edge w+7; the PATTERN write sampled there replaces it.
        log_cyc.delete();
        log_dat.delete();
        bus_write(2'd1, 16'h005A, wc);
        wait_until(wc + 6);
        check_window("blink_rewrite", wc, wc + 5, 1, 8'h5A, 1);
        stop_seq("blink");

        // ---------------- randomized runs ----------------
        for (int it = 0; it < 8; it++) begin
            mode = int'($urandom_range(0, 3));
            p    = 8'($urandom);
            per  = int'($urandom_range(0, 3));
            len  = int'($urandom_range(3, 14));
            start_seq($sformatf("rnd%0d", it), mode, p, per, w);
            wait_until(w + len + 1);
            check_window($sformatf("rnd%0d", it), w, w + len, mode, p, per);
            stop_seq($sformatf("rnd%0d", it));
        end

        // ---------------- reset mid-run ----------------
        start_seq("mrst", 3, 8'h10, 0, w);
        wait_until(w + 3);
        bus_read(2'd1, rd);
        check("mrst_pre_led_wr", led_wr, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check("mrst_led_wr", led_wr, 1'b0);
        check("mrst_led_data", led_data, 16'h0000);
        check("mrst_data_out", data_out, 16'h0000);
        log_cyc.delete();
        log_dat.delete();
        step();
        #2;
        rst_n = 1'b1;
        step();
        repeat (10) step();
        check("mrst_no_led_wr", log_cyc.size(), 0);
        bus_read(2'd2, rd);
        check("mrst_period", rd, 16'd49999);
        bus_read(2'd0, rd);
        check("mrst_ctrl", rd, 16'h0000);
        bus_read(2'd3, rd);
        check("mrst_cur", rd, 16'h0000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
